// File: rtl/csr_arbiter_if.sv
// Bus bundle for csr_arbiter: two master request/response ports plus the
// shared CSR port.
//   slave  modport : the arbiter's view. It takes in mN_req/we/a/di and csr_do,
//                    and drives out mN_ack/mN_do and csr_a/csr_di/csr_we.
//   master modport : the environment's view, which is the two masters plus the
//                    CSR slave.
interface csr_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_a;
  logic [DATA_WIDTH-1:0] m0_di;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_do;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_a;
  logic [DATA_WIDTH-1:0] m1_di;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_do;

  logic [ADDR_WIDTH-1:0] csr_a;
  logic [DATA_WIDTH-1:0] csr_di;
  logic                  csr_we;
  logic [DATA_WIDTH-1:0] csr_do;

  modport slave (
    input  m0_req, m0_we, m0_a, m0_di,
    input  m1_req, m1_we, m1_a, m1_di,
    input  csr_do,
    output m0_ack, m0_do, m1_ack, m1_do,
    output csr_a, csr_di, csr_we
  );

  modport master (
    output m0_req, m0_we, m0_a, m0_di,
    output m1_req, m1_we, m1_a, m1_di,
    output csr_do,
    input  m0_ack, m0_do, m1_ack, m1_do,
    input  csr_a, csr_di, csr_we
  );
endinterface

// File: rtl/csr_arbiter.sv
// csr_arbiter: lets two bus masters share one CSR port, one transaction at a
// time. Arbitration is round-robin (FAIR=1) or fixed priority with m0 on top
// (FAIR=0).
// Each transaction runs IDLE -> XFER -> CAPT -> ACK, and every state lasts one
// cycle. All outputs are registered.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active high
//   bus  : csr_arbiter_if.slave. It carries the mN_req/we/a/di inputs and the
//          mN_ack/mN_do outputs, plus the shared csr_a/csr_di/csr_we outputs
//          and the csr_do input.
module csr_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter bit FAIR       = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  csr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_CAPT = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;          // 0 = m0, 1 = m1
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] csr_a_q, csr_a_d;
  logic [DATA_WIDTH-1:0] csr_di_q, csr_di_d;
  logic                  csr_we_q, csr_we_d;
  logic                  m0_ack_q, m0_ack_d;
  logic                  m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0] m0_do_q, m0_do_d;
  logic [DATA_WIDTH-1:0] m1_do_q, m1_do_d;
  logic                  winner;

  // Winner is only meaningful when at least one master is requesting.
  always_comb begin
    winner = 1'b0;
    if (FAIR) begin
      if (bus.m0_req && bus.m1_req) winner = ~last_grant_q;
      else                          winner = bus.m1_req;
    end else begin
      winner = ~bus.m0_req;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    csr_a_d      = csr_a_q;
    csr_di_d     = csr_di_q;
    csr_we_d     = 1'b0;        // the write strobe lasts for the XFER cycle only
    m0_ack_d     = 1'b0;        // acks are set in CAPT, so they show during ACK
    m1_ack_d     = 1'b0;
    m0_do_d      = m0_do_q;
    m1_do_d      = m1_do_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant_d      = winner;
          last_grant_d = winner;
          csr_we_d     = winner ? bus.m1_we : bus.m0_we;
          csr_a_d      = winner ? bus.m1_a  : bus.m0_a;
          csr_di_d     = winner ? bus.m1_di : bus.m0_di;
          state_d      = S_XFER;
        end
      end
      S_XFER: state_d = S_CAPT;
      S_CAPT: begin
        // The slave registers csr_do one cycle after csr_a, so csr_do is valid
        // here. Writes capture it too, which returns the old register contents.
        if (grant_q) begin
          m1_do_d  = bus.csr_do;
          m1_ack_d = 1'b1;
        end else begin
          m0_do_d  = bus.csr_do;
          m0_ack_d = 1'b1;
        end
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;   // req is deliberately not sampled here
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;        // so that m0 wins the first contention
      csr_a_q      <= '0;
      csr_di_q     <= '0;
      csr_we_q     <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_do_q      <= '0;
      m1_do_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      csr_a_q      <= csr_a_d;
      csr_di_q     <= csr_di_d;
      csr_we_q     <= csr_we_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_do_q      <= m0_do_d;
      m1_do_q      <= m1_do_d;
    end
  end

  assign bus.csr_a  = csr_a_q;
  assign bus.csr_di = csr_di_q;
  assign bus.csr_we = csr_we_q;
  assign bus.m0_ack = m0_ack_q;
  assign bus.m1_ack = m1_ack_q;
  assign bus.m0_do  = m0_do_q;
  assign bus.m1_do  = m1_do_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed testbench for csr_arbiter. Two instances are used. u_fair has
// FAIR=1 and talks to a register-file slave model. u_prio has FAIR=0 and talks
// to a slave that returns {3'b0, csr_a}. Inputs are driven 1 time unit after
// posedge, and outputs are sampled on negedge.
module tb_csr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  csr_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) if_f ();
  csr_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) if_p ();

  csr_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .FAIR(1'b1)) u_fair (
    .clk (clk),
    .rst (rst),
    .bus (if_f.slave)
  );

  csr_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .FAIR(1'b0)) u_prio (
    .clk (clk),
    .rst (rst),
    .bus (if_p.slave)
  );

  // Register-file slave for u_fair. csr_do returns the old contents of csr_a
  // one cycle later. The preload port lets the bench seed registers.
  logic [7:0] mem_f [32];
  logic       pl_en = 1'b0;
  logic [4:0] pl_a  = '0;
  logic [7:0] pl_d  = '0;
  always @(posedge clk) begin
    if (pl_en) mem_f[pl_a] <= pl_d;
    else if (if_f.csr_we) mem_f[if_f.csr_a] <= if_f.csr_di;
    if_f.csr_do <= mem_f[if_f.csr_a];
  end

  always @(posedge clk) if_p.csr_do <= {3'b000, if_p.csr_a};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Runs a single transaction on u_fair and records what it observes. The
  // request is dropped on the edge that samples ack. Sampling continues for
  // 12 cycles so that any extra strobe is caught.
  task automatic run_xact(input bit m, input bit we, input logic [4:0] a,
                          input logic [7:0] di, output int ack_cyc,
                          output logic [7:0] rdata, output int we_cnt,
                          output logic [4:0] wa, output logic [7:0] wdi,
                          output bit other_ack);
    bit acked;
    ack_cyc = -1; rdata = '0; we_cnt = 0; wa = '0; wdi = '0; other_ack = 1'b0;
    if (m) begin
      if_f.m1_req = 1'b1; if_f.m1_we = we; if_f.m1_a = a; if_f.m1_di = di;
    end else begin
      if_f.m0_req = 1'b1; if_f.m0_we = we; if_f.m0_a = a; if_f.m0_di = di;
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (if_f.csr_we) begin
        we_cnt++; wa = if_f.csr_a; wdi = if_f.csr_di;
      end
      acked = m ? if_f.m1_ack : if_f.m0_ack;
      if (m ? if_f.m0_ack : if_f.m1_ack) other_ack = 1'b1;
      if (acked && ack_cyc < 0) begin
        ack_cyc = n;
        rdata = m ? if_f.m1_do : if_f.m0_do;
      end
      step();
      if (acked) begin
        if (m) if_f.m1_req = 1'b0;
        else   if_f.m0_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (if_f.csr_we !== 1'b0) begin errors++; $display("FAIL rst_csr_we got=%b exp=0", if_f.csr_we); end
    checks++; if (if_f.csr_a !== 5'h00) begin errors++; $display("FAIL rst_csr_a got=%h exp=00", if_f.csr_a); end
    checks++; if (if_f.csr_di !== 8'h00) begin errors++; $display("FAIL rst_csr_di got=%h exp=00", if_f.csr_di); end
    checks++; if ({if_f.m0_ack, if_f.m1_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got=%b exp=00", {if_f.m0_ack, if_f.m1_ack}); end
    checks++; if ({if_f.m0_do, if_f.m1_do} !== 16'h0000) begin errors++; $display("FAIL rst_do got=%h exp=0000", {if_f.m0_do, if_f.m1_do}); end
    checks++; if (int'(u_fair.state_q) !== 0) begin errors++; $display("FAIL rst_state got=%0d exp=0", int'(u_fair.state_q)); end
    checks++; if (u_fair.last_grant_q !== 1'b1) begin errors++; $display("FAIL rst_last_grant got=%b exp=1", u_fair.last_grant_q); end
    checks++; if ({if_p.csr_we, if_p.m0_ack, if_p.m1_ack} !== 3'b000) begin errors++; $display("FAIL rst_prio_outs got=%b exp=000", {if_p.csr_we, if_p.m0_ack, if_p.m1_ack}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_m0_read();
    int ack_cyc, we_cnt; logic [7:0] rdata, wdi; logic [4:0] wa; bit oth;
    preload(5'h02, 8'h3C);
    run_xact(1'b0, 1'b0, 5'h02, 8'h00, ack_cyc, rdata, we_cnt, wa, wdi, oth);
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL m0_read_we_count got=%0d exp=0", we_cnt); end
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL m0_read_ack_cycle got=%0d exp=3", ack_cyc); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL m0_read_data got=%h exp=3c", rdata); end
    checks++; if (oth !== 1'b0) begin errors++; $display("FAIL m0_read_m1_ack got=%b exp=0", oth); end
  endtask

  task automatic test_m1_write_read();
    int ack_cyc, we_cnt; logic [7:0] rdata, wdi; logic [4:0] wa; bit oth;
    run_xact(1'b1, 1'b1, 5'h01, 8'hA5, ack_cyc, rdata, we_cnt, wa, wdi, oth);
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL m1_write_we_count got=%0d exp=1", we_cnt); end
    checks++; if (wa !== 5'h01) begin errors++; $display("FAIL m1_write_addr got=%h exp=01", wa); end
    checks++; if (wdi !== 8'hA5) begin errors++; $display("FAIL m1_write_data got=%h exp=a5", wdi); end
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL m1_write_ack_cycle got=%0d exp=3", ack_cyc); end
    checks++; if (oth !== 1'b0) begin errors++; $display("FAIL m1_write_m0_ack got=%b exp=0", oth); end
    run_xact(1'b1, 1'b0, 5'h01, 8'h00, ack_cyc, rdata, we_cnt, wa, wdi, oth);
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL m1_read_we_count got=%0d exp=0", we_cnt); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL m1_read_data got=%h exp=a5", rdata); end
    checks++; if (if_f.m0_do !== 8'h3C) begin errors++; $display("FAIL m0_do_hold got=%h exp=3c", if_f.m0_do); end
  endtask

  task automatic test_round_robin();
    bit seq [4]; int cyc [4]; logic [7:0] dat [4]; int nacks = 0; bit both = 1'b0;
    bit exp_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int exp_cyc [4] = '{3, 7, 11, 15};
    logic [7:0] exp_dat [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    preload(5'h03, 8'h11);
    preload(5'h04, 8'h22);
    do_reset();
    if_f.m0_req = 1'b1; if_f.m0_we = 1'b0; if_f.m0_a = 5'h03;
    if_f.m1_req = 1'b1; if_f.m1_we = 1'b0; if_f.m1_a = 5'h04;
    for (int n = 0; n < 40 && nacks < 4; n++) begin
      @(negedge clk);
      if (if_f.m0_ack && if_f.m1_ack) both = 1'b1;
      if (if_f.m0_ack || if_f.m1_ack) begin
        seq[nacks] = if_f.m1_ack;
        cyc[nacks] = n;
        dat[nacks] = if_f.m1_ack ? if_f.m1_do : if_f.m0_do;
        nacks++;
      end
      step();
    end
    if_f.m0_req = 1'b0; if_f.m1_req = 1'b0;
    checks++; if (nacks !== 4) begin errors++; $display("FAIL rr_ack_count got=%0d exp=4", nacks); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_double_ack got=%b exp=0", both); end
    for (int i = 0; i < 4; i++) begin
      if (i < nacks) begin
        checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_winner[%0d] got=m%0d exp=m%0d", i, seq[i], exp_seq[i]); end
        checks++; if (cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL rr_cycle[%0d] got=%0d exp=%0d", i, cyc[i], exp_cyc[i]); end
        checks++; if (dat[i] !== exp_dat[i]) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, dat[i], exp_dat[i]); end
      end
    end
    repeat (3) step();
  endtask

  task automatic test_fixed_priority();
    int m0_acks = 0; bit m1_seen = 1'b0; bit bad_do = 1'b0; int m1_cyc = -1;
    logic [7:0] m1_dat = '0;
    do_reset();
    if_p.m0_req = 1'b1; if_p.m0_we = 1'b0; if_p.m0_a = 5'h09; if_p.m0_di = '0;
    if_p.m1_req = 1'b1; if_p.m1_we = 1'b0; if_p.m1_a = 5'h0A; if_p.m1_di = '0;
    for (int n = 0; n < 40 && m0_acks < 4; n++) begin
      @(negedge clk);
      if (if_p.m1_ack) m1_seen = 1'b1;
      if (if_p.m0_ack) begin
        m0_acks++;
        if (if_p.m0_do !== 8'h09) bad_do = 1'b1;
      end
      step();
    end
    if_p.m0_req = 1'b0;
    checks++; if (m0_acks !== 4) begin errors++; $display("FAIL prio_m0_acks got=%0d exp=4", m0_acks); end
    checks++; if (m1_seen !== 1'b0) begin errors++; $display("FAIL prio_m1_starved got=%b exp=0", m1_seen); end
    checks++; if (bad_do !== 1'b0) begin errors++; $display("FAIL prio_m0_do got=%b exp=0 (bad data flag)", bad_do); end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (if_p.m1_ack && m1_cyc < 0) begin m1_cyc = n; m1_dat = if_p.m1_do; end
      step();
      if (m1_cyc >= 0) if_p.m1_req = 1'b0;
    end
    if_p.m1_req = 1'b0;
    checks++; if (m1_cyc !== 3) begin errors++; $display("FAIL prio_m1_served_cycle got=%0d exp=3", m1_cyc); end
    checks++; if (m1_dat !== 8'h0A) begin errors++; $display("FAIL prio_m1_data got=%h exp=0a", m1_dat); end
  endtask

  task automatic test_reset_mid_xfer();
    bit late_ack = 1'b0;
    int ack_cyc, we_cnt; logic [7:0] rdata, wdi; logic [4:0] wa; bit oth;
    do_reset();
    if_f.m0_req = 1'b1; if_f.m0_we = 1'b1; if_f.m0_a = 5'h05; if_f.m0_di = 8'h77;
    @(negedge clk);                 // IDLE samples the request
    step();                         // now in XFER
    rst = 1'b1;
    @(negedge clk);
    checks++; if (int'(u_fair.state_q) !== 1) begin errors++; $display("FAIL abort_in_xfer got=%0d exp=1", int'(u_fair.state_q)); end
    checks++; if (if_f.csr_we !== 1'b1) begin errors++; $display("FAIL abort_xfer_we got=%b exp=1", if_f.csr_we); end
    step();
    rst = 1'b0; if_f.m0_req = 1'b0;
    @(negedge clk);
    checks++; if (if_f.csr_we !== 1'b0) begin errors++; $display("FAIL abort_we_cleared got=%b exp=0", if_f.csr_we); end
    checks++; if (int'(u_fair.state_q) !== 0) begin errors++; $display("FAIL abort_state got=%0d exp=0", int'(u_fair.state_q)); end
    checks++; if (u_fair.last_grant_q !== 1'b1) begin errors++; $display("FAIL abort_last_grant got=%b exp=1", u_fair.last_grant_q); end
    for (int n = 0; n < 6; n++) begin
      if (if_f.m0_ack) late_ack = 1'b1;
      @(negedge clk);
    end
    checks++; if (late_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack got=%b exp=0", late_ack); end
    step();
    preload(5'h06, 8'h5A);
    run_xact(1'b0, 1'b0, 5'h06, 8'h00, ack_cyc, rdata, we_cnt, wa, wdi, oth);
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL post_abort_ack_cycle got=%0d exp=3", ack_cyc); end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL post_abort_data got=%h exp=5a", rdata); end
  endtask

  task automatic test_back_to_back();
    int acks = 0; int ack_cyc [2] = '{-1, -1}; logic [7:0] d0 = '0;
    int we_cnt = 0; int we_n = -1; logic [4:0] wa = '0; logic [7:0] wdi = '0;
    bit acked;
    preload(5'h07, 8'h81);
    preload(5'h08, 8'h00);
    do_reset();
    if_f.m0_req = 1'b1; if_f.m0_we = 1'b0; if_f.m0_a = 5'h07; if_f.m0_di = 8'h00;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (if_f.csr_we) begin we_cnt++; we_n = n; wa = if_f.csr_a; wdi = if_f.csr_di; end
      acked = if_f.m0_ack;
      if (acked) begin
        if (acks < 2) ack_cyc[acks] = n;
        if (acks == 0) d0 = if_f.m0_do;
        acks++;
      end
      step();
      if (acked && acks == 1) begin
        if_f.m0_we = 1'b1; if_f.m0_a = 5'h08; if_f.m0_di = 8'h42;
      end else if (acked) begin
        if_f.m0_req = 1'b0;
      end
    end
    if_f.m0_req = 1'b0;
    checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_ack_count got=%0d exp=2", acks); end
    checks++; if (ack_cyc[0] !== 3) begin errors++; $display("FAIL b2b_first_ack got=%0d exp=3", ack_cyc[0]); end
    checks++; if (ack_cyc[1] !== 7) begin errors++; $display("FAIL b2b_second_ack got=%0d exp=7", ack_cyc[1]); end
    checks++; if (d0 !== 8'h81) begin errors++; $display("FAIL b2b_read_data got=%h exp=81", d0); end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL b2b_we_count got=%0d exp=1", we_cnt); end
    checks++; if (we_n !== 5) begin errors++; $display("FAIL b2b_we_cycle got=%0d exp=5", we_n); end
    checks++; if ({wa, wdi} !== {5'h08, 8'h42}) begin errors++; $display("FAIL b2b_we_addr_data got=%h/%h exp=08/42", wa, wdi); end
    checks++; if (mem_f[8] !== 8'h42) begin errors++; $display("FAIL b2b_slave_reg got=%h exp=42", mem_f[8]); end
  endtask

  initial begin
    if_f.m0_req = 1'b0; if_f.m0_we = 1'b0; if_f.m0_a = '0; if_f.m0_di = '0;
    if_f.m1_req = 1'b0; if_f.m1_we = 1'b0; if_f.m1_a = '0; if_f.m1_di = '0;
    if_p.m0_req = 1'b0; if_p.m0_we = 1'b0; if_p.m0_a = '0; if_p.m0_di = '0;
    if_p.m1_req = 1'b0; if_p.m1_we = 1'b0; if_p.m1_a = '0; if_p.m1_di = '0;
    test_reset();
    test_m0_read();
    test_m1_write_read();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid_xfer();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
